instruction_fetch_pipe: RTL
===========================

Name: instruction_fetch_pipe

Overview:
- Pipelined fetch stage; sits directly upstream of the ID stage.
- Owns the fetch PC and drives the instruction memory through a req/gnt/rvalid handshake.
- Registers the fetched word into the IF/ID pipeline register (instruction_IFID, pc_IFID, pc_4_IFID) with stall, flush/redirect and a one-entry hold buffer.
- Injects NOP bubbles whenever no valid instruction is available.

Parameters:
WIDTH, 32, datapath and address width
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INST, 32'h0000_0013, bubble encoding (ADDI x0,x0,0)

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-low; asserted when 0 at posedge clk
stall_ID  input  1  hazard unit: hold IF/ID contents
flush  input  1  taken branch/jump resolved downstream: redirect fetch
branch_target  input  WIDTH  redirect address, valid when flush=1; bits [1:0] ignored (treated as 00)
imem_req  output  1  fetch request (combinational)
imem_addr  output  WIDTH  fetch address (combinational, = fetch PC)
imem_gnt  input  1  request accepted when imem_req && imem_gnt
imem_rvalid  input  1  response valid; exactly one per accepted request, in order, at least 1 cycle after acceptance
imem_rdata  input  WIDTH  instruction word, valid with imem_rvalid
instruction_IFID  output  WIDTH  IF/ID instruction
pc_IFID  output  WIDTH  IF/ID PC of that instruction
pc_4_IFID  output  WIDTH  IF/ID pc_IFID+4
valid_IFID  output  1  1 = real instruction, 0 = bubble

Behaviour:
- Reset (reset==0 at posedge):
  - pc_f=RESET_PC; state=FETCH; hold buffer empty.
  - instruction_IFID=NOP_INST, pc_IFID=0, pc_4_IFID=0, valid_IFID=0.
  - imem_req=0 while reset==0.
  - Reset overrides everything, including mid-transaction: any rvalid seen in FETCH state is ignored.
- States: FETCH, WAIT, HOLD, DROP.
- At most one outstanding request. imem_req is forced 0 whenever flush=1.
- Request rules:
  - FETCH: imem_req=1, imem_addr=pc_f. On acceptance: pc_f<=pc_f+4, req_pc<=pc_f, go to WAIT. No acceptance: stay.
  - WAIT: imem_req=1 only in a cycle where imem_rvalid && !stall_ID && !flush (back-to-back fetch).
- Response handling in WAIT, on rvalid:
  - stall_ID=0: IF/ID<=(imem_rdata, req_pc, req_pc+4, valid 1). If a new request is accepted the same cycle, stay in WAIT; otherwise go to FETCH.
  - stall_ID=1: hold buffer<=(rdata, req_pc); go to HOLD; IF/ID unchanged.
- HOLD: imem_req=0. When stall_ID=0: IF/ID<=hold buffer (valid 1), buffer cleared, go to FETCH.
- IF/ID update rules:
  - stall_ID=1 and flush=0: IF/ID holds all values.
  - Not stalled and no instruction delivered: IF/ID loads bubble (NOP_INST, pc 0, pc_4 0, valid 0).
- Flush (priority: reset > flush > stall):
  - pc_f<=branch_target & ~3; IF/ID<=bubble; hold buffer cleared.
  - Next state from WAIT: rvalid this cycle → FETCH (response discarded); otherwise → DROP.
  - Next state from FETCH or HOLD: FETCH.
- DROP: imem_req=0. On rvalid, discard the response and go to FETCH. A flush while in DROP updates pc_f and stays in DROP.
- Throughput: with gnt=1 and 1-cycle response latency, one instruction per cycle after a 2-cycle startup.
- Arithmetic:
  - All PC adds are WIDTH-bit modulo (32'hFFFF_FFFC+4=0).
  - imem_addr[1:0] is always 00.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined:
  - Adds outputs fetch_count (32) and bubble_count (32), both reset to 0.
  - fetch_count increments on each IF/ID load with valid 1.
  - bubble_count increments on each IF/ID load of a bubble, including flush bubbles. Cycles where IF/ID holds under stall do not count.
  - Both counters wrap modulo 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, gnt=1, 1-cycle rvalid, memory word[i]=0x1000_0000+i → imem_addr 0,4,8…; IF/ID shows pc 0,4,8 with pc_4 4,8,12 and valid 1 every cycle from the 3rd cycle after reset deasserts.
- Stall_ID for 3 cycles while a response arrives → IF/ID frozen, response goes to HOLD; on release the held instruction (pc 0x8) appears once, no duplicate and no loss, then fetch resumes at 0xC.
- Flush with branch_target=0x0000_0103 while in WAIT, rvalid arriving 2 cycles later → stale word discarded; next imem_addr=0x100; IF/ID bubble (NOP 0x13, valid 0) until the 0x100 instruction arrives.
- Flush and rvalid in the same cycle → response dropped, state FETCH, next request at the target; flush with stall_ID=1 → IF/ID becomes bubble (flush wins).
- pc_f=0xFFFF_FFFC fetch → next imem_addr 0x0; pc_4_IFID=0x0.
- reset=0 asserted mid-WAIT with rvalid pending → outputs return to reset values; the first post-reset fetch is RESET_PC; with IF_PERF_CNT_EN defined, counters read 0 and then match the valid and bubble loads seen.

Source files
------------

// File: rtl/instruction_fetch_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_pipe_if
// Brief    : Fetch-stage bundle: hazard/redirect inputs, imem req/gnt/rvalid
//            handshake and the IF/ID pipeline register outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface instruction_fetch_pipe_if #(
  parameter int WIDTH = 32
) ();
  logic             stall_ID;
  logic             flush;
  logic [WIDTH-1:0] branch_target;
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_gnt;
  logic             imem_rvalid;
  logic [WIDTH-1:0] imem_rdata;
  logic [WIDTH-1:0] instruction_IFID;
  logic [WIDTH-1:0] pc_IFID;
  logic [WIDTH-1:0] pc_4_IFID;
  logic             valid_IFID;

  modport master (
    input  stall_ID, flush, branch_target, imem_gnt, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, instruction_IFID, pc_IFID, pc_4_IFID, valid_IFID
  );

  modport slave (
    output stall_ID, flush, branch_target, imem_gnt, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, instruction_IFID, pc_IFID, pc_4_IFID, valid_IFID
  );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch_pipe.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_pipe
// Brief    : Pipelined fetch stage with one outstanding imem request, IF/ID
//            register, stall hold buffer and flush/redirect handling.
//            Optional macro IF_PERF_CNT_EN adds fetch/bubble counters.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_pipe #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [WIDTH-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic                      clk,
  input  logic                      reset,
  instruction_fetch_pipe_if.master  bus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]               fetch_count,
  output logic [31:0]               bubble_count
`endif
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DROP  = 2'd3;

  localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(4);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] pc_f_q, pc_f_d;
  logic [WIDTH-1:0] req_pc_q, req_pc_d;
  logic [WIDTH-1:0] hold_inst_q, hold_inst_d;
  logic [WIDTH-1:0] hold_pc_q, hold_pc_d;
  logic [WIDTH-1:0] inst_q, inst_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc4_q, pc4_d;
  logic             valid_q, valid_d;

  logic             w_req;
  logic             w_accept;
  logic             w_load_valid;
  logic             w_load_bubble;
  logic [WIDTH-1:0] w_ld_inst;
  logic [WIDTH-1:0] w_ld_pc;

  // Back-to-back request only when the current response is consumed this cycle
  always_comb begin
    w_req = 1'b0;
    if (reset && !bus.flush) begin
      case (state_q)
        S_FETCH: w_req = 1'b1;
        S_WAIT:  w_req = bus.imem_rvalid && !bus.stall_ID;
        default: w_req = 1'b0;
      endcase
    end
  end

  assign w_accept     = w_req && bus.imem_gnt;
  assign bus.imem_req  = w_req;
  assign bus.imem_addr = pc_f_q;

  always_comb begin
    state_d       = state_q;
    pc_f_d        = pc_f_q;
    req_pc_d      = req_pc_q;
    hold_inst_d   = hold_inst_q;
    hold_pc_d     = hold_pc_q;
    w_load_valid  = 1'b0;
    w_load_bubble = 1'b0;
    w_ld_inst     = hold_inst_q;
    w_ld_pc       = hold_pc_q;

    if (bus.flush) begin
      pc_f_d        = bus.branch_target & ALIGN_MASK;
      hold_inst_d   = '0;
      hold_pc_d     = '0;
      w_load_bubble = 1'b1;
      case (state_q)
        S_WAIT:  state_d = bus.imem_rvalid ? S_FETCH : S_DROP;
        S_DROP:  state_d = bus.imem_rvalid ? S_FETCH : S_DROP;
        default: state_d = S_FETCH;
      endcase
    end else begin
      case (state_q)
        S_FETCH: begin
          w_load_bubble = !bus.stall_ID;
          if (w_accept) begin
            pc_f_d   = pc_f_q + PC_STEP;
            req_pc_d = pc_f_q;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.imem_rvalid) begin
            if (bus.stall_ID) begin
              hold_inst_d = bus.imem_rdata;
              hold_pc_d   = req_pc_q;
              state_d     = S_HOLD;
            end else begin
              w_load_valid = 1'b1;
              w_ld_inst    = bus.imem_rdata;
              w_ld_pc      = req_pc_q;
              if (w_accept) begin
                pc_f_d   = pc_f_q + PC_STEP;
                req_pc_d = pc_f_q;
              end else begin
                state_d = S_FETCH;
              end
            end
          end else begin
            w_load_bubble = !bus.stall_ID;
          end
        end
        S_HOLD: begin
          if (!bus.stall_ID) begin
            w_load_valid = 1'b1;
            hold_inst_d  = '0;
            hold_pc_d    = '0;
            state_d      = S_FETCH;
          end
        end
        default: begin
          w_load_bubble = !bus.stall_ID;
          if (bus.imem_rvalid) begin
            state_d = S_FETCH;
          end
        end
      endcase
    end
  end

  always_comb begin
    inst_d  = inst_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (w_load_valid) begin
      inst_d  = w_ld_inst;
      pc_d    = w_ld_pc;
      pc4_d   = w_ld_pc + PC_STEP;
      valid_d = 1'b1;
    end else if (w_load_bubble) begin
      inst_d  = NOP_INST;
      pc_d    = '0;
      pc4_d   = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_FETCH;
      pc_f_q      <= RESET_PC;
      req_pc_q    <= '0;
      hold_inst_q <= '0;
      hold_pc_q   <= '0;
      inst_q      <= NOP_INST;
      pc_q        <= '0;
      pc4_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_f_q      <= pc_f_d;
      req_pc_q    <= req_pc_d;
      hold_inst_q <= hold_inst_d;
      hold_pc_q   <= hold_pc_d;
      inst_q      <= inst_d;
      pc_q        <= pc_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
    end
  end

  assign bus.instruction_IFID = inst_q;
  assign bus.pc_IFID          = pc_q;
  assign bus.pc_4_IFID        = pc4_q;
  assign bus.valid_IFID       = valid_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] bubble_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (w_load_valid) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (w_load_bubble) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_count  = fetch_cnt_q;
  assign bubble_count = bubble_cnt_q;
`endif

endmodule
`default_nettype wire
